awgn_seq_ctrl: RTL

- Sequencer for the Box-Muller AWGN datapath: uniform RNG -> -2ln(u0) -> sqrt CORDIC, and sin/cos CORDIC on u1 -> products x0/x1.
- Owns the two 32-bit uniform generators and issues tvalid to the sqrt and sin/cos CORDICs.
- Collects both CORDIC completions and captures the x0/x1 pair.
- Serialises the pair onto one valid/ready sample stream; sits between the datapath and the channel-model consumer.

---
 rtl/awgn_pkg.sv | 28 ++
 rtl/awgn_seq_ctrl_if.sv | 11 +
 rtl/awgn_xorshift32.sv | 25 ++
 rtl/awgn_seq_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/awgn_pkg.sv
// Shared types and constants for the AWGN Box-Muller sequencer.
package awgn_pkg;

    localparam int unsigned SAMPLE_W_DEF = 16;

    localparam int unsigned XS_SHL1 = 13;
    localparam int unsigned XS_SHR  = 17;
    localparam int unsigned XS_SHL2 = 5;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        ISSUE,
        WAIT,
        CAPTURE,
        EMIT0,
        EMIT1
    } state_t;

    function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << XS_SHL1);
        t = t ^ (t >> XS_SHR);
        t = t ^ (t << XS_SHL2);
        return t;
    endfunction

endpackage

// File: rtl/awgn_seq_ctrl_if.sv
// Output sample stream (valid/ready) between the sequencer and the channel-model consumer.
interface awgn_seq_ctrl_if #(
    parameter int unsigned SAMPLE_W = awgn_pkg::SAMPLE_W_DEF
);
    logic                out_tvalid;
    logic                out_tready;
    logic [SAMPLE_W-1:0] out_tdata;

    modport master (output out_tvalid, output out_tdata, input out_tready);
    modport slave  (input out_tvalid, input out_tdata, output out_tready);
endinterface

// File: rtl/awgn_xorshift32.sv
// 32-bit xorshift uniform generator with seed load (zero seed forced to 1) and step enable.
module awgn_xorshift32
    import awgn_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= (seed == '0) ? 32'h0000_0001 : seed;
        end else if (step) begin
            state <= xorshift32_next(state);
        end
    end

endmodule

// File: rtl/awgn_seq_ctrl.sv
// Box-Muller AWGN sequencer: steps the uniform generators, fires the CORDICs, collects the x0/x1 pair
// and serialises it. Optional statistics counters are enabled with `define AWGN_SEQ_STATS_EN.
module awgn_seq_ctrl
    import awgn_pkg::*;
#(
    parameter int unsigned SAMPLE_W       = SAMPLE_W_DEF,
    parameter int unsigned TIMEOUT_CYC    = 64,
    parameter logic [31:0] DEFAULT_SEED_A = 32'h0000_0001,
    parameter logic [31:0] DEFAULT_SEED_B = 32'h0000_0002
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                seed_load,
    input  logic [31:0]         urng_seed1,
    input  logic [31:0]         urng_seed2,
    output logic [31:0]         urng_a,
    output logic [31:0]         urng_b,
    output logic                sqrt_tvalid,
    output logic                phase_tvalid,
    input  logic                sqrt_dout_tvalid,
    input  logic                sincos_dout_tvalid,
    input  logic [SAMPLE_W-1:0] x0_in,
    input  logic [SAMPLE_W-1:0] x1_in,
    awgn_seq_ctrl_if.master     out_if,
    output logic                busy,
    output logic                err
`ifdef AWGN_SEQ_STATS_EN
    ,
    output logic [31:0]         pair_count,
    output logic [15:0]         timeout_count
`endif
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state, state_n;
    logic [TMR_W-1:0]    timer;
    logic                sqrt_done, sincos_done;
    logic [SAMPLE_W-1:0] buf0, buf1;
    logic                gen_step, abort, pair_done, both_seen;

    awgn_xorshift32 #(.RESET_SEED(DEFAULT_SEED_A)) u_urng_a (
        .clk   (clk),
        .reset (reset),
        .load  (seed_load),
        .seed  (urng_seed1),
        .step  (gen_step),
        .state (urng_a)
    );

    awgn_xorshift32 #(.RESET_SEED(DEFAULT_SEED_B)) u_urng_b (
        .clk   (clk),
        .reset (reset),
        .load  (seed_load),
        .seed  (urng_seed2),
        .step  (gen_step),
        .state (urng_b)
    );

    // Completions landing in the current cycle count alongside the sticky flags.
    assign both_seen = (sqrt_done | sqrt_dout_tvalid) & (sincos_done | sincos_dout_tvalid);

    always_comb begin
        state_n           = state;
        gen_step          = 1'b0;
        abort             = 1'b0;
        pair_done         = 1'b0;
        sqrt_tvalid       = 1'b0;
        phase_tvalid      = 1'b0;
        out_if.out_tvalid = 1'b0;
        out_if.out_tdata  = '0;
        case (state)
            IDLE:    if (enable) state_n = STEP;
            STEP: begin
                gen_step = 1'b1;
                state_n  = ISSUE;
            end
            ISSUE: begin
                sqrt_tvalid  = 1'b1;
                phase_tvalid = 1'b1;
                state_n      = WAIT;
            end
            WAIT: begin
                if (both_seen) begin
                    state_n = CAPTURE;
                end else if (timer >= TMR_W'(TIMEOUT_CYC - 1)) begin
                    abort   = 1'b1;
                    state_n = STEP;
                end
            end
            CAPTURE: state_n = EMIT0;
            EMIT0: begin
                out_if.out_tvalid = 1'b1;
                out_if.out_tdata  = buf0;
                if (out_if.out_tready) state_n = EMIT1;
            end
            EMIT1: begin
                out_if.out_tvalid = 1'b1;
                out_if.out_tdata  = buf1;
                if (out_if.out_tready) begin
                    pair_done = 1'b1;
                    state_n   = enable ? STEP : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            sqrt_done   <= 1'b0;
            sincos_done <= 1'b0;
            buf0        <= '0;
            buf1        <= '0;
            err         <= 1'b0;
        end else if (seed_load) begin
            state       <= IDLE;
            timer       <= '0;
            sqrt_done   <= 1'b0;
            sincos_done <= 1'b0;
            buf0        <= '0;
            buf1        <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ISSUE) begin
                timer       <= '0;
                sqrt_done   <= 1'b0;
                sincos_done <= 1'b0;
            end else if (state == WAIT) begin
                if (timer != TMR_W'(TIMEOUT_CYC)) timer <= timer + 1'b1;
                if (sqrt_dout_tvalid)   sqrt_done   <= 1'b1;
                if (sincos_dout_tvalid) sincos_done <= 1'b1;
            end
            if (state == CAPTURE) begin
                buf0 <= x0_in;
                buf1 <= x1_in;
            end
            if (abort) err <= 1'b1;
        end
    end

    assign busy = (state != IDLE);

`ifdef AWGN_SEQ_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pair_count    <= '0;
            timeout_count <= '0;
        end else if (seed_load) begin
            pair_count    <= '0;
            timeout_count <= '0;
        end else begin
            if (pair_done) pair_count    <= pair_count + 1'b1;
            if (abort)     timeout_count <= timeout_count + 1'b1;
        end
    end
`else
    logic unused_pair_done;
    assign unused_pair_done = pair_done;
`endif

endmodule
